fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of instruction_memory. It owns the program counter and drives the word-indexed pc_address into instruction memory. It captures the combinationally returned instruction_set into an IF/ID pipeline register for the decoder. It handles stalls, taken-branch redirects with flush, and end-of-program halt.

---
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage in front of instruction_memory. Owns the program
// counter (a word index), presents it on pc_address, and registers the
// combinationally returned instruction_set into the IF/ID register. It also
// handles downstream stalls, taken-branch redirects (one-bubble flush), and
// halting after the last memory word.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   stall           hold request from hazard logic
//   branch_taken    redirect request from execute
//   branch_target   redirect word index
//   pc_address      current PC, straight from the PC register
//   instruction_set instruction word for pc_address, same cycle
//   if_valid        IF/ID register holds a real instruction
//   if_instruction  IF/ID instruction word
//   if_pc           word index the IF/ID instruction came from
//   halted          high while in HALT
//   fetch_count     (FETCH_PERF_COUNT_EN only) saturating count of fetches
//   stall_count     (FETCH_PERF_COUNT_EN only) saturating count of stalled RUN cycles
//
// Optional feature macro: FETCH_PERF_COUNT_EN adds the two perf counters.
//
// State table:
//   state | meaning
//   RUN   | fetching one word per cycle, honouring stall and branch
//   HALT  | past the last word; PC parked at MEM_DEPTH-1, only a branch restarts

module fetch_unit #(
    parameter int PC_WIDTH  = 32,
    parameter int MEM_DEPTH = 32,
    parameter int RESET_PC  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc_address,
    input  logic [31:0]         instruction_set,
    output logic                if_valid,
    output logic [31:0]         if_instruction,
    output logic [PC_WIDTH-1:0] if_pc,
`ifdef FETCH_PERF_COUNT_EN
    output logic [15:0]         fetch_count,
    output logic [15:0]         stall_count,
`endif
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] LAST_PC  = PC_WIDTH'(MEM_DEPTH - 1);
    localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(RESET_PC);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                if_valid_q, if_valid_d;
    logic [31:0]         if_instruction_q, if_instruction_d;
    logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;

    // Pulses used by the optional perf counters; computed unconditionally
    // so the FSM logic is identical in both builds.
    logic                fetch_evt;
    logic                stall_evt;
    logic                target_in_range;

    // Targets are word indices, so anything past the last word is out of range.
    assign target_in_range = (branch_target <= LAST_PC);

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_valid_d       = if_valid_q;
        if_instruction_d = if_instruction_q;
        if_pc_d          = if_pc_q;
        fetch_evt        = 1'b0;
        stall_evt        = 1'b0;

        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    if_valid_d = 1'b0;
                    if (target_in_range) begin
                        pc_d             = branch_target;
                        if_instruction_d = '0;
                    end else begin
                        pc_d    = LAST_PC;
                        state_d = HALT;
                    end
                end else if (stall) begin
                    stall_evt = 1'b1;
                end else begin
                    if_instruction_d = instruction_set;
                    if_pc_d          = pc_q;
                    if_valid_d       = 1'b1;
                    fetch_evt        = 1'b1;
                    // The last word is still delivered; PC parks on it.
                    if (pc_q == LAST_PC) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + PC_WIDTH'(1);
                    end
                end
            end
            HALT: begin
                if_valid_d = 1'b0;
                if (branch_taken && target_in_range) begin
                    pc_d    = branch_target;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            pc_q             <= START_PC;
            if_valid_q       <= 1'b0;
            if_instruction_q <= '0;
            if_pc_q          <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_valid_q       <= if_valid_d;
            if_instruction_q <= if_instruction_d;
            if_pc_q          <= if_pc_d;
        end
    end

    assign pc_address     = pc_q;
    assign if_valid       = if_valid_q;
    assign if_instruction = if_instruction_q;
    assign if_pc          = if_pc_q;
    assign halted         = (state_q == HALT);

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (fetch_evt && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
        if (stall_evt && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    // Event pulses have no consumer in this build.
    logic unused_evt;
    assign unused_evt = fetch_evt ^ stall_evt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a reference model predicts the post-edge outputs
// for each driven cycle, pushes them on a scoreboard queue, and the entry is
// popped and compared once the DUT has taken the edge. Directed checks follow
// the test plan scenarios.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc_address;
    logic [31:0] instruction_set;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        halted;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.PC_WIDTH(32), .MEM_DEPTH(32), .RESET_PC(0)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .pc_address      (pc_address),
        .instruction_set (instruction_set),
        .if_valid        (if_valid),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc),
`ifdef FETCH_PERF_COUNT_EN
        .fetch_count     (fetch_count),
        .stall_count     (stall_count),
`endif
        .halted          (halted)
    );

    logic [31:0] mem [32];
    initial for (int k = 0; k < 32; k++) mem[k] = 32'hC0DE_0000 + (k * 7) + 1;

    assign instruction_set = (pc_address < 32) ? mem[pc_address[4:0]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic        halt;
        logic [15:0] fc;
        logic [15:0] sc;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_pc = 0;
    logic        m_valid = 0;
    logic [31:0] m_instr = 0;
    logic [31:0] m_ifpc = 0;
    logic        m_halt = 0;
    logic [15:0] m_fc = 0;
    logic [15:0] m_sc = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic s, input logic b, input logic [31:0] t, input logic r);
        if (r) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_ifpc = 0; m_halt = 0; m_fc = 0; m_sc = 0;
        end else if (!m_halt) begin
            if (b) begin
                m_valid = 0;
                if (t < 32) begin
                    m_pc = t; m_instr = 0;
                end else begin
                    m_pc = 31; m_halt = 1;
                end
            end else if (s) begin
                if (m_sc != 16'hFFFF) m_sc = m_sc + 1;
            end else begin
                m_instr = mem[m_pc[4:0]];
                m_ifpc  = m_pc;
                m_valid = 1;
                if (m_fc != 16'hFFFF) m_fc = m_fc + 1;
                if (m_pc == 31) m_halt = 1;
                else m_pc = m_pc + 1;
            end
        end else begin
            m_valid = 0;
            if (b && t < 32) begin
                m_pc = t; m_halt = 0;
            end
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic r);
        exp_t e;
        @(negedge clk);
        stall = s; branch_taken = b; branch_target = t; rst = r;
        model_edge(s, b, t, r);
        e.pc = m_pc; e.valid = m_valid; e.instr = m_instr; e.ifpc = m_ifpc;
        e.halt = m_halt; e.fc = m_fc; e.sc = m_sc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_pc", pc_address, e.pc);
        chk("sb_valid", {31'b0, if_valid}, {31'b0, e.valid});
        chk("sb_instr", if_instruction, e.instr);
        chk("sb_ifpc", if_pc, e.ifpc);
        chk("sb_halt", {31'b0, halted}, {31'b0, e.halt});
`ifdef FETCH_PERF_COUNT_EN
        chk("sb_fcnt", {16'b0, fetch_count}, {16'b0, e.fc});
        chk("sb_scnt", {16'b0, stall_count}, {16'b0, e.sc});
`endif
    endtask

    initial begin
        // reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_pc", pc_address, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_ifpc", if_pc, 32'd0);
        chk("rst_halt", {31'b0, halted}, 32'd0);

        // sequential fetch
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("seq_pc", pc_address, 32'd5);
        chk("seq_ifpc", if_pc, 32'd4);
        chk("seq_instr", if_instruction, mem[4]);
        chk("seq_valid", {31'b0, if_valid}, 32'd1);

        // stall at pc 2
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("stall_pc", pc_address, 32'd2);
        chk("stall_ifpc", if_pc, 32'd1);
        chk("stall_instr", if_instruction, mem[1]);
        chk("stall_valid", {31'b0, if_valid}, 32'd1);
        step(0, 0, 0, 0);
        chk("release_ifpc", if_pc, 32'd2);

        // branch at pc 3 to 7
        step(0, 1, 7, 0);
        chk("br_pc", pc_address, 32'd7);
        chk("br_bubble", {31'b0, if_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("br_ifpc", if_pc, 32'd7);
        chk("br_instr", if_instruction, mem[7]);
        chk("br_valid", {31'b0, if_valid}, 32'd1);

        // branch beats stall, then out-of-range halt
        step(1, 1, 12, 0);
        chk("brstall_pc", pc_address, 32'd12);
        chk("brstall_valid", {31'b0, if_valid}, 32'd0);
        step(0, 1, 40, 0);
        chk("oor_halt", {31'b0, halted}, 32'd1);
        chk("oor_pc", pc_address, 32'd31);

        // restart and run to the last word
        step(0, 1, 20, 0);
        chk("restart_halt", {31'b0, halted}, 32'd0);
        chk("restart_pc", pc_address, 32'd20);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 0);
        chk("end_pc", pc_address, 32'd31);
        chk("end_nohalt", {31'b0, halted}, 32'd0);
        step(0, 0, 0, 0);
        chk("last_ifpc", if_pc, 32'd31);
        chk("last_valid", {31'b0, if_valid}, 32'd1);
        chk("last_halt", {31'b0, halted}, 32'd1);
        chk("last_pc", pc_address, 32'd31);
        step(1, 0, 0, 0);
        chk("halt_valid", {31'b0, if_valid}, 32'd0);
        chk("halt_pc", pc_address, 32'd31);
        step(0, 1, 0, 0);
        chk("wake_halt", {31'b0, halted}, 32'd0);
        chk("wake_pc", pc_address, 32'd0);

        // random mix
        for (int i = 0; i < 60; i++) begin
            logic s, b;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = $urandom_range(0, 40);
            step(s, b, t, 0);
        end

        // reset mid-run with stall and branch asserted
        step(1, 1, 5, 1);
        chk("midrst_pc", pc_address, 32'd0);
        chk("midrst_valid", {31'b0, if_valid}, 32'd0);
        chk("midrst_halt", {31'b0, halted}, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        chk("midrst_fcnt", {16'b0, fetch_count}, 32'd0);
        chk("midrst_scnt", {16'b0, stall_count}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
